// File: rtl/cache_refill_pkg.sv
// Shared types and sizing helpers for the cache refill (miss handler) block.
package cache_refill_pkg;

   typedef enum logic [2:0] {IDLE, LOOKUP, MREQ, MWAIT, FILL, RESP} cache_refill_state_e;

   localparam int PERF_CNT_W = 32;

   // Width of the word-within-line index; never below 1 so the beat counter stays legal.
   function automatic int word_off_w(input int block_size, input int word_size);
      return (block_size / word_size > 1) ? $clog2(block_size / word_size) : 1;
   endfunction

endpackage

// File: rtl/cache_refill_if.sv
// Core request/response, cache read/write and memory ports of the refill block, bundled.
interface cache_refill_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BLOCK_SIZE = 128,
   parameter int WORD_SIZE  = 32
);
   logic                      req_valid;
   logic                      req_ready;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [WORD_SIZE-1:0]      resp_data;
   logic [ADDR_WIDTH-1:0]     rif_addr;
   logic [BLOCK_SIZE-1:0]     rif_data;
   logic                      rif_hit;
   logic [ADDR_WIDTH-1:0]     wif_addr;
   logic [BLOCK_SIZE-1:0]     wif_data;
   logic [BLOCK_SIZE/8-1:0]   wif_we;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic [ADDR_WIDTH-1:0]     mem_req_addr;
   logic                      mem_resp_valid;
   logic [WORD_SIZE-1:0]      mem_resp_data;

   modport master (
      input  req_valid, req_addr, resp_ready, rif_data, rif_hit,
             mem_req_ready, mem_resp_valid, mem_resp_data,
      output req_ready, resp_valid, resp_data, rif_addr, wif_addr, wif_data, wif_we,
             mem_req_valid, mem_req_addr
   );

   modport slave (
      output req_valid, req_addr, resp_ready, rif_data, rif_hit,
             mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, resp_valid, resp_data, rif_addr, wif_addr, wif_data, wif_we,
             mem_req_valid, mem_req_addr
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter for the refill perf statistics; present only with CACHE_REFILL_PERF_EN.
`ifdef CACHE_REFILL_PERF_EN
module sat_counter
   import cache_refill_pkg::*;
#(
   parameter int WIDTH = PERF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/cache_refill.sv
// Cache miss handler: hit response 2 cycles after accept, miss refills the line one word at a time.
// req_ready only in IDLE, response held until resp_ready; CACHE_REFILL_PERF_EN adds hit/miss counters.
module cache_refill
   import cache_refill_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int BLOCK_SIZE = 128,
   parameter int WORD_SIZE  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef CACHE_REFILL_PERF_EN
   output logic [PERF_CNT_W-1:0] perf_hit_cnt,
   output logic [PERF_CNT_W-1:0] perf_miss_cnt,
`endif
   cache_refill_if.master        bus
);

   localparam int WORDS    = BLOCK_SIZE / WORD_SIZE;
   localparam int BOFF     = $clog2(WORD_SIZE / 8);
   localparam int WOFF_W   = word_off_w(BLOCK_SIZE, WORD_SIZE);
   localparam int LINE_OFF = BOFF + WOFF_W;
   localparam logic [WOFF_W-1:0] BEAT_LAST = WOFF_W'(WORDS - 1);

   cache_refill_state_e                 state;
   logic [ADDR_WIDTH-1:0]               addr_q;
   logic [WORDS-1:0][WORD_SIZE-1:0]     line_q;
   logic [WOFF_W-1:0]                   beat;
   logic [WORD_SIZE-1:0]                resp_q;
   logic                                req_ready_q;
   logic                                resp_valid_q;
   logic                                mem_req_valid_q;
   logic [BLOCK_SIZE/8-1:0]             wif_we_q;

   logic [WORDS-1:0][WORD_SIZE-1:0]     rif_words;
   logic [WOFF_W-1:0]                   woff;

   assign rif_words = bus.rif_data;
   assign woff      = addr_q[BOFF +: WOFF_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         addr_q          <= '0;
         line_q          <= '0;
         beat            <= '0;
         resp_q          <= '0;
         req_ready_q     <= 1'b1;
         resp_valid_q    <= 1'b0;
         mem_req_valid_q <= 1'b0;
         wif_we_q        <= '0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               addr_q      <= bus.req_addr;
               req_ready_q <= 1'b0;
               state       <= LOOKUP;
            end
            LOOKUP: if (bus.rif_hit) begin
               resp_q       <= rif_words[woff];
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end else begin
               beat            <= '0;
               mem_req_valid_q <= 1'b1;
               state           <= MREQ;
            end
            MREQ: if (bus.mem_req_ready) begin
               mem_req_valid_q <= 1'b0;
               state           <= MWAIT;
            end
            // One request in flight: the next beat is only requested once this one returns.
            MWAIT: if (bus.mem_resp_valid) begin
               line_q[beat] <= bus.mem_resp_data;
               if (beat == BEAT_LAST) begin
                  wif_we_q <= '1;
                  state    <= FILL;
               end else begin
                  beat            <= beat + 1'b1;
                  mem_req_valid_q <= 1'b1;
                  state           <= MREQ;
               end
            end
            FILL: begin
               wif_we_q     <= '0;
               resp_q       <= line_q[woff];
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end
            RESP: if (bus.resp_ready) begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready     = req_ready_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_data     = resp_q;
   assign bus.rif_addr      = addr_q;
   assign bus.wif_addr      = {addr_q[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
   assign bus.wif_data      = line_q;
   assign bus.wif_we        = wif_we_q;
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_addr  = {addr_q[ADDR_WIDTH-1:LINE_OFF], beat, {BOFF{1'b0}}};

`ifdef CACHE_REFILL_PERF_EN
   logic in_lookup;
   assign in_lookup = (state == LOOKUP);

   sat_counter #(.WIDTH(PERF_CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (in_lookup && bus.rif_hit),
      .count (perf_hit_cnt)
   );

   sat_counter #(.WIDTH(PERF_CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (in_lookup && !bus.rif_hit),
      .count (perf_miss_cnt)
   );
`endif

endmodule
